// File: rtl/mod_reduce.sv
// mod_reduce: sequential C mod M reducer using a restoring shift-subtract loop.
// Optional build macro MOD_REDUCE_RADIX4_EN retires two quotient bits per cycle.
`default_nettype none

module mod_reduce #(
  parameter int N = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] prod,
  input  logic [N-1:0]   mod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   res,
  output logic           err
);

  localparam int C_CNT_W = $clog2(2 * N);
`ifdef MOD_REDUCE_RADIX4_EN
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(N - 1);
`else
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(2 * N - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [2*N-1:0]       r_s;
  logic [N-1:0]         r_mod;
  logic [N-1:0]         r_rem;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [N-1:0]         r_res;
  logic                 r_err;
  logic [N-1:0]         w_rem_step1;
  logic [N-1:0]         w_rem_next;
  logic [2*N-1:0]       w_s_next;
  logic                 w_accept;

  // The remainder is kept below the modulus, so it needs only N bits; the
  // shifted-in trial value T is N+1 bits wide and never underflows.
  function automatic logic [N-1:0] rem_step(input logic [N-1:0] r,
                                            input logic         b,
                                            input logic [N-1:0] m);
    logic [N:0] t;
    t = {r, b};
    if (t >= {1'b0, m}) rem_step = N'(t - {1'b0, m});
    else                rem_step = N'(t);
  endfunction

  assign w_rem_step1 = rem_step(r_rem, r_s[2*N-1], r_mod);

`ifdef MOD_REDUCE_RADIX4_EN
  assign w_rem_next = rem_step(w_rem_step1, r_s[2*N-2], r_mod);
  assign w_s_next   = {r_s[2*N-3:0], 2'b00};
`else
  assign w_rem_next = w_rem_step1;
  assign w_s_next   = {r_s[2*N-2:0], 1'b0};
`endif

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE) && !rst;
  assign res       = rst ? '0 : r_res;
  assign err       = r_err && !rst;
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = (mod == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (r_cnt == C_LAST) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_mod   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_s   <= prod;
            r_mod <= mod;
            r_rem <= '0;
            r_cnt <= '0;
            r_res <= '0;
            r_err <= (mod == '0);
          end
        end
        S_RUN: begin
          r_s   <= w_s_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_res <= w_rem_next;
            r_err <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire
